// File: rtl/chess_clock_mode_ctrl.sv
// Chess-clock mode controller: conditions DE10 KEY/SW inputs and sequences the game-mode word for the HPS PIO.
// Optional build macro CHESS_MODE_IRQ_EN adds a sticky irq/irq_ack handshake alongside mode_chg.
module chess_clock_mode_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  key_raw,
    input  logic [7:0]  sw_raw,
`ifdef CHESS_MODE_IRQ_EN
    input  logic        irq_ack,
    output logic        irq,
`endif
    output logic [31:0] mode_word,
    output logic        mode_chg
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Keys idle high (active-low buttons), switches idle low.
    localparam logic [11:0] IN_RST = 12'h00F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_A  = 2'd1,
        RUN_B  = 2'd2,
        PAUSED = 2'd3
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [11:0]      sync_q [SYNC_STAGES];
    logic [11:0]      sync_w;
    logic [11:0]      deb_q;
    logic [CNT_W-1:0] cnt_q [12];
    logic [3:0]       key_prev_q;
    logic [3:0]       press_q;

    state_t      state_q, state_d;
    logic        resume_q, resume_d;
    logic [7:0]  moves_q, moves_d;
    logic [7:0]  preset_q, preset_d;
    logic [7:0]  seq_q, seq_d;
    logic [31:0] mode_word_q, mode_word_d;
    logic        mode_chg_q, mode_chg_d;
    logic        upd_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= IN_RST;
        end else begin
            sync_q[0] <= {sw_raw, key_raw};
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];

    // Each bit needs DEBOUNCE_CYCLES consecutive disagreeing samples before the debounced level follows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_q <= IN_RST;
            for (int i = 0; i < 12; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 12; i++) begin
                if (sync_w[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    deb_q[i] <= sync_w[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_prev_q <= 4'hF;
            press_q    <= 4'h0;
        end else begin
            key_prev_q <= deb_q[3:0];
            press_q    <= key_prev_q & ~deb_q[3:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            resume_q    <= 1'b0;
            moves_q     <= 8'h00;
            preset_q    <= 8'h00;
            seq_q       <= 8'h00;
            mode_word_q <= 32'h0;
            mode_chg_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            moves_q     <= moves_d;
            preset_q    <= preset_d;
            seq_q       <= seq_d;
            mode_word_q <= mode_word_d;
            mode_chg_q  <= mode_chg_d;
        end
    end

    // Priority among simultaneous presses: pause/resume, then new/abort, then player moves.
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        moves_d  = moves_q;
        case (state_q)
            IDLE: begin
                if (press_q[0]) begin
                    state_d = RUN_A;
                    moves_d = 8'h00;
                end
            end
            RUN_A: begin
                if (press_q[3]) begin
                    state_d  = PAUSED;
                    resume_d = 1'b0;
                end else if (press_q[1]) begin
                    state_d = RUN_B;
                    moves_d = sat_inc8(moves_q);
                end
            end
            RUN_B: begin
                if (press_q[3]) begin
                    state_d  = PAUSED;
                    resume_d = 1'b1;
                end else if (press_q[2]) begin
                    state_d = RUN_A;
                    moves_d = sat_inc8(moves_q);
                end
            end
            PAUSED: begin
                if (press_q[3]) begin
                    state_d = resume_q ? RUN_B : RUN_A;
                end else if (press_q[0]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Presets follow the switches while idle (including the entry cycle) and freeze once a game starts.
        preset_d = ((state_q == IDLE) || (state_d == IDLE)) ? deb_q[11:4] : preset_q;
    end

    always_comb begin
        upd_w       = (state_d != state_q) || (moves_d != moves_q) || (preset_d != preset_q);
        seq_d       = upd_w ? seq_q + 8'd1 : seq_q;
        mode_word_d = mode_word_q;
        if (upd_w) begin
            mode_word_d = {seq_d, moves_d, 4'h0, preset_d, 1'b0, resume_d, state_d};
        end
        mode_chg_d  = upd_w;
    end

    assign mode_word = mode_word_q;
    assign mode_chg  = mode_chg_q;

`ifdef CHESS_MODE_IRQ_EN
    logic irq_q;

    // A new update outranks a coincident acknowledge so no change is ever lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else if (mode_chg_q) begin
            irq_q <= 1'b1;
        end else if (irq_ack) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_chess_clock_mode_ctrl.sv
// Bench for chess_clock_mode_ctrl: directed scenarios plus randomized key/switch activity against a game-rule model.
`timescale 1ns/1ps
module tb_chess_clock_mode_ctrl;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int GAP  = 10;
    localparam int LAT  = SYNC + DEB + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  key_raw = 4'hF;
    logic [7:0]  sw_raw = 8'h00;
    logic [31:0] mode_word;
    logic        mode_chg;
`ifdef CHESS_MODE_IRQ_EN
    logic        irq;
    logic        irq_ack = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    int chg_cnt = 0;
    int exp_chg = 0;

    // Game-rule model: 0 idle, 1 A running, 2 B running, 3 paused.
    int         m_state = 0;
    bit         m_resume = 1'b0;
    int         m_moves = 0;
    logic [7:0] m_preset = 8'h00;
    logic [7:0] sw_cur = 8'h00;
    logic [7:0] m_seq = 8'h00;

    always #5 clk = ~clk;

    chess_clock_mode_ctrl #(
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_raw(key_raw),
        .sw_raw(sw_raw),
`ifdef CHESS_MODE_IRQ_EN
        .irq_ack(irq_ack),
        .irq(irq),
`endif
        .mode_word(mode_word),
        .mode_chg(mode_chg)
    );

    always @(negedge clk) if (mode_chg) chg_cnt <= chg_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word();
        return {m_seq, 8'(m_moves), 4'h0, m_preset, 1'b0, m_resume, 2'(m_state)};
    endfunction

    task automatic note_update(input bit ch);
        if (ch) begin
            m_seq = m_seq + 8'd1;
            exp_chg++;
        end
    endtask

    task automatic model_press(input int k);
        bit ch;
        ch = 1'b0;
        case (m_state)
            0: if (k == 0) begin m_state = 1; m_moves = 0; m_preset = sw_cur; ch = 1'b1; end
            1: if (k == 3) begin m_state = 3; m_resume = 1'b0; ch = 1'b1; end
               else if (k == 1) begin m_state = 2; if (m_moves < 255) m_moves++; ch = 1'b1; end
            2: if (k == 3) begin m_state = 3; m_resume = 1'b1; ch = 1'b1; end
               else if (k == 2) begin m_state = 1; if (m_moves < 255) m_moves++; ch = 1'b1; end
            3: if (k == 3) begin m_state = m_resume ? 2 : 1; ch = 1'b1; end
               else if (k == 0) begin m_state = 0; m_preset = sw_cur; ch = 1'b1; end
            default: ;
        endcase
        note_update(ch);
    endtask

    task automatic model_sw(input logic [7:0] v);
        sw_cur = v;
        if (m_state == 0 && v != m_preset) begin
            m_preset = v;
            note_update(1'b1);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_word"}, mode_word, exp_word());
        chk({tag, "_chg"}, chg_cnt, exp_chg);
    endtask

    task automatic press_mask(input logic [3:0] mask);
        key_raw = ~mask;
        repeat (HOLD) @(negedge clk);
        key_raw = 4'hF;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic do_press(input int k, input string tag);
        press_mask(4'(1 << k));
        model_press(k);
        check_all(tag);
    endtask

    task automatic set_sw(input logic [7:0] v, input string tag);
        sw_raw = v;
        repeat (GAP + 2) @(negedge clk);
        model_sw(v);
        check_all(tag);
    endtask

    task automatic glitch(input int k, input int len);
        key_raw[k] = 1'b0;
        repeat (len) @(negedge clk);
        key_raw[k] = 1'b1;
        repeat (GAP) @(negedge clk);
        check_all("glitch");
    endtask

    initial begin
        int lat;
        bit found;

        repeat (3) @(negedge clk);
        chk("por_word", mode_word, 32'h0);
        chk("por_chg", {31'b0, mode_chg}, 32'h0);
        reset = 1'b0;
        repeat (GAP) @(negedge clk);
        check_all("idle_quiet");

        set_sw(8'h53, "idle_preset");

        // Bouncing start key: only the final steady low counts.
        key_raw[0] = 1'b0; repeat (2) @(negedge clk);
        key_raw[0] = 1'b1; repeat (2) @(negedge clk);
        key_raw[0] = 1'b0; repeat (2) @(negedge clk);
        key_raw[0] = 1'b1; repeat (2) @(negedge clk);
        key_raw[0] = 1'b0;
        lat = 0;
        found = 1'b0;
        for (int n = 1; n <= 20 && !found; n++) begin
            @(negedge clk);
            if (mode_chg) begin
                lat = n;
                found = 1'b1;
            end
        end
        chk("start_latency", lat, LAT);
        repeat (4) @(negedge clk);
        key_raw[0] = 1'b1;
        repeat (GAP) @(negedge clk);
        model_press(0);
        check_all("start");
        chk("start_preset", {24'h0, mode_word[11:4]}, 32'h53);

        set_sw(8'hFF, "sw_locked");
        chk("locked_preset", {24'h0, mode_word[11:4]}, 32'h53);

        do_press(0, "run_new_ignored");
        do_press(2, "runa_b_ignored");
        do_press(1, "a_done");
        do_press(1, "runb_a_ignored");
        do_press(3, "pause_b");
        chk("pause_resume_bit", {31'b0, mode_word[2]}, 32'h1);
        do_press(1, "paused_a_ignored");
        do_press(3, "resume_b");
        chk("resume_state", {30'b0, mode_word[1:0]}, 32'h2);
        do_press(3, "pause_b2");
        do_press(0, "abort_idle");
        chk("abort_state", {30'b0, mode_word[1:0]}, 32'h0);

        do_press(0, "restart");
        for (int i = 0; i < 300; i++) do_press((i % 2 == 0) ? 1 : 2, "alt_move");
        chk("moves_saturated", {24'h0, mode_word[23:16]}, 32'd255);
        chk("after_alt_state", {30'b0, mode_word[1:0]}, 32'h1);

        press_mask(4'b1010);
        model_press(3);
        check_all("same_cycle_pause");
        set_sw(8'h00, "paused_sw");

        key_raw[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_word", mode_word, 32'h0);
        chk("midrst_chg", {31'b0, mode_chg}, 32'h0);
        key_raw = 4'hF;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_state = 0; m_resume = 1'b0; m_moves = 0; m_preset = 8'h00; m_seq = 8'h00;
        repeat (15) @(negedge clk);
        check_all("post_reset");

`ifdef CHESS_MODE_IRQ_EN
        chk("irq_after_reset", {31'b0, irq}, 32'h0);
        set_sw(8'h11, "irq_upd1");
        chk("irq_set", {31'b0, irq}, 32'h1);
        repeat (3) @(negedge clk);
        chk("irq_hold", {31'b0, irq}, 32'h1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq_cleared", {31'b0, irq}, 32'h0);
        set_sw(8'h22, "irq_upd2");
        sw_raw = 8'h33;
        found = 1'b0;
        for (int n = 1; n <= 20 && !found; n++) begin
            @(negedge clk);
            if (mode_chg) found = 1'b1;
        end
        chk("irq_chg_seen", {31'b0, found}, 32'h1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq_set_wins", {31'b0, irq}, 32'h1);
        repeat (GAP) @(negedge clk);
        model_sw(8'h33);
        check_all("irq_upd3");
        chk("irq_still_set", {31'b0, irq}, 32'h1);
`endif

        for (int it = 0; it < 150; it++) begin
            int r;
            int k;
            logic [7:0] v;
            r = $urandom_range(0, 9);
            k = $urandom_range(0, 3);
            if (r < 6) begin
                do_press(k, "rnd_press");
            end else if (r < 8) begin
                glitch(k, $urandom_range(1, 3));
            end else begin
                v = 8'($urandom);
                set_sw(v, "rnd_sw");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
